fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one cache read at a time, holds the
// returned word for decode until accepted, and handles redirects. A read
// that is in flight when a redirect arrives is never abandoned. Instead it
// is tagged for squash, and its data is dropped when it comes back.
module fetch_unit #(
  parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic        o_Cache_RdEn,
  output logic [31:0] o_Cache_Addr,
  input  logic        i_Cache_Stall,
  input  logic [31:0] i_Cache_RdData,
  output logic [31:0] o_Instr,
  output logic [31:0] o_PC,
  output logic        o_Valid,
  input  logic        i_Ready,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC
);

  // Word alignment is enforced by masking, so fetch addresses keep [1:0] = 0.
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL = P_RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC_AL;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      opc_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
    end
  end

  // Next-state logic: normal fetch sequencing first, then redirect overrides.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;

    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!i_Cache_Stall) begin
          if (squash_q) begin
            // Stale word from before a redirect: drop it and refetch.
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            instr_d = i_Cache_RdData;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_Ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (i_Redirect) begin
      pc_d    = i_RedirectPC & ALIGN_MASK;
      valid_d = 1'b0;
      // Any word captured this cycle belongs to the old path.
      instr_d = instr_q;
      opc_d   = opc_q;
      case (state_q)
        S_REQ: begin
          // The request just issued is still in flight.
          squash_d = 1'b1;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (i_Cache_Stall) begin
            squash_d = 1'b1;
            state_d  = S_WAIT;
          end else begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  assign o_Cache_RdEn = (state_q == S_REQ);
  assign o_Cache_Addr = pc_q;
  assign o_Instr      = instr_q;
  assign o_PC         = opc_q;
  assign o_Valid      = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for the main fetch/stall/hold/redirect
// flow, plus hand sequences for reset behaviour and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, ready, redir;
  logic [31:0] rpc, key;
  logic        rden, valid;
  logic [31:0] addr, instr, pc, rdata;

  logic        rst2;
  logic        rden2, valid2;
  logic [31:0] addr2, instr2, pc2, rdata2;
  logic [31:0] lat, lat2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.P_RESET_PC(32'h0000_0000)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .o_Cache_RdEn(rden), .o_Cache_Addr(addr),
    .i_Cache_Stall(stall), .i_Cache_RdData(rdata),
    .o_Instr(instr), .o_PC(pc), .o_Valid(valid),
    .i_Ready(ready), .i_Redirect(redir), .i_RedirectPC(rpc)
  );

  fetch_unit #(.P_RESET_PC(32'hFFFF_FFFC)) dut2 (
    .i_Clk(clk), .i_Rst(rst2),
    .o_Cache_RdEn(rden2), .o_Cache_Addr(addr2),
    .i_Cache_Stall(1'b0), .i_Cache_RdData(rdata2),
    .o_Instr(instr2), .o_PC(pc2), .o_Valid(valid2),
    .i_Ready(1'b1), .i_Redirect(1'b0), .i_RedirectPC(32'h0)
  );

  // Cache models: remember the accepted address and return it (optionally
  // XORed with a per-cycle key so instruction and PC can be told apart).
  always @(posedge clk or negedge rst)
    if (!rst) lat <= 32'h0;
    else if (rden) lat <= addr;
  assign rdata = lat ^ key;

  always @(posedge clk or negedge rst2)
    if (!rst2) lat2 <= 32'h0;
    else if (rden2) lat2 <= addr2;
  assign rdata2 = lat2;

  typedef struct {
    logic        stall, ready, redir;
    logic [31:0] rpc, key;
    logic        e_rden;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic r, input logic d,
                              input logic [31:0] p, input logic [31:0] k,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.ready = r; v.redir = d; v.rpc = p; v.key = k;
    v.e_rden = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    chk({tag, "_rden"},  {31'h0, rden},  {31'h0, er});
    chk({tag, "_addr"},  addr,           ea);
    chk({tag, "_valid"}, {31'h0, valid}, {31'h0, ev});
    chk({tag, "_pc"},    pc,             ep);
    chk({tag, "_instr"}, instr,          ei);
  endtask

  task automatic chk_all2(input string tag, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    chk({tag, "_rden"},  {31'h0, rden2},  {31'h0, er});
    chk({tag, "_addr"},  addr2,           ea);
    chk({tag, "_valid"}, {31'h0, valid2}, {31'h0, ev});
    chk({tag, "_pc"},    pc2,             ep);
    chk({tag, "_instr"}, instr2,          ei);
  endtask

  initial begin
    // Columns: stall ready redir rpc key | rden addr valid pc instr
    tbl.push_back(mk(0,1,0,0,0,            1,32'h000,0,32'h000,32'h000)); // c0  REQ 0
    tbl.push_back(mk(0,1,0,0,0,            0,32'h000,0,32'h000,32'h000)); // c1  WAIT
    tbl.push_back(mk(0,1,0,0,0,            0,32'h004,1,32'h000,32'h000)); // c2  HOLD pc0
    tbl.push_back(mk(0,1,0,0,0,            1,32'h004,0,32'h000,32'h000)); // c3  REQ 4
    tbl.push_back(mk(0,1,0,0,0,            0,32'h004,0,32'h000,32'h000)); // c4
    tbl.push_back(mk(0,1,0,0,0,            0,32'h008,1,32'h004,32'h004)); // c5  HOLD pc4
    tbl.push_back(mk(0,1,0,0,0,            1,32'h008,0,32'h004,32'h004)); // c6  REQ 8
    tbl.push_back(mk(1,1,0,0,0,            0,32'h008,0,32'h004,32'h004)); // c7  stall
    tbl.push_back(mk(1,1,0,0,0,            0,32'h008,0,32'h004,32'h004)); // c8  stall
    tbl.push_back(mk(1,1,0,0,0,            0,32'h008,0,32'h004,32'h004)); // c9  stall
    tbl.push_back(mk(0,1,0,0,0,            0,32'h008,0,32'h004,32'h004)); // c10 stall drops
    tbl.push_back(mk(0,0,0,0,0,            0,32'h00C,1,32'h008,32'h008)); // c11 HOLD pc8, not ready
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,0,          0,32'h00C,1,32'h008,32'h008)); // c12..c15
    tbl.push_back(mk(0,1,0,0,0,            0,32'h00C,1,32'h008,32'h008)); // c16 ready
    tbl.push_back(mk(0,1,0,0,0,            1,32'h00C,0,32'h008,32'h008)); // c17 REQ C
    tbl.push_back(mk(0,1,0,0,32'h5A00_0000,0,32'h00C,0,32'h008,32'h008)); // c18
    tbl.push_back(mk(0,1,0,0,0,            0,32'h010,1,32'h00C,32'h5A00_000C)); // c19
    tbl.push_back(mk(0,1,0,0,0,            1,32'h010,0,32'h00C,32'h5A00_000C)); // c20 REQ 10
    tbl.push_back(mk(1,1,0,0,0,            0,32'h010,0,32'h00C,32'h5A00_000C)); // c21 stall
    tbl.push_back(mk(1,1,1,32'h103,0,      0,32'h010,0,32'h00C,32'h5A00_000C)); // c22 redirect
    tbl.push_back(mk(1,1,0,0,0,            0,32'h100,0,32'h00C,32'h5A00_000C)); // c23
    tbl.push_back(mk(0,1,0,0,0,            0,32'h100,0,32'h00C,32'h5A00_000C)); // c24 stale returns
    tbl.push_back(mk(0,1,0,0,0,            1,32'h100,0,32'h00C,32'h5A00_000C)); // c25 REQ 100
    tbl.push_back(mk(0,1,0,0,0,            0,32'h100,0,32'h00C,32'h5A00_000C)); // c26
    tbl.push_back(mk(0,1,0,0,0,            0,32'h104,1,32'h100,32'h100));       // c27
    tbl.push_back(mk(0,1,1,32'h200,0,      1,32'h104,0,32'h100,32'h100)); // c28 redirect in REQ
    tbl.push_back(mk(1,1,1,32'h302,0,      0,32'h200,0,32'h100,32'h100)); // c29 2nd redirect
    tbl.push_back(mk(0,1,0,0,0,            0,32'h300,0,32'h100,32'h100)); // c30 squashed data
    tbl.push_back(mk(0,1,0,0,0,            1,32'h300,0,32'h100,32'h100)); // c31 REQ 300
    tbl.push_back(mk(0,1,1,32'h400,0,      0,32'h300,0,32'h100,32'h100)); // c32 redirect, data ready
    tbl.push_back(mk(0,1,0,0,0,            1,32'h400,0,32'h100,32'h100)); // c33 REQ 400
    tbl.push_back(mk(0,1,0,0,32'h1111_0000,0,32'h400,0,32'h100,32'h100)); // c34
    tbl.push_back(mk(0,1,1,32'h500,0,      0,32'h404,1,32'h400,32'h1111_0400)); // c35 redirect in HOLD
    tbl.push_back(mk(0,1,0,0,0,            1,32'h500,0,32'h400,32'h1111_0400)); // c36 REQ 500
    tbl.push_back(mk(0,1,0,0,0,            0,32'h500,0,32'h400,32'h1111_0400)); // c37
    tbl.push_back(mk(0,1,0,0,0,            0,32'h504,1,32'h500,32'h500));       // c38
    tbl.push_back(mk(0,1,0,0,0,            1,32'h504,0,32'h500,32'h500));       // c39

    rst = 1'b0; rst2 = 1'b0;
    stall = 1'b0; ready = 1'b1; redir = 1'b0; rpc = 32'h0; key = 32'h0;

    // Reset state, both instances.
    repeat (2) @(negedge clk);
    chk_all("rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    chk_all2("rst2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);

    // Release so that the first table row is the cycle right after release.
    @(posedge clk); #1 rst = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      chk_all($sformatf("c%0d", i), tbl[i].e_rden, tbl[i].e_addr,
              tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_instr);
      stall = tbl[i].stall; ready = tbl[i].ready; redir = tbl[i].redir;
      rpc = tbl[i].rpc; key = tbl[i].key;
    end

    // c39 advances into S_WAIT; assert reset between edges.
    stall = 1'b1; ready = 1'b1; redir = 1'b0; key = 32'h0;
    @(posedge clk); #2;
    chk("pre_arst_rden", {31'h0, rden}, 32'h0);
    rst = 1'b0; #1;
    chk_all("arst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); chk_all("rel0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk_all("rel1", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk_all("rel2", 1'b0, 32'h4, 1'b1, 32'h0, 32'h0);

    // Wrap-around from the top of the address space.
    @(posedge clk); #1 rst2 = 1'b1;
    @(negedge clk); chk_all2("w0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk_all2("w1", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk_all2("w2", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    @(negedge clk); chk_all2("w3", 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    @(negedge clk); chk_all2("w4", 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    @(negedge clk); chk_all2("w5", 1'b0, 32'h4, 1'b1, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
